// File: rtl/morse_keyer.sv
// ---------------------------------------------------------------------------
// morse_keyer
//   Timed Morse transmitter. Accepts one character per valid/ready handshake
//   as a dot/dash pattern plus an element count, and drives a key line with
//   standard Morse timing (dot 1u, dash 3u, element gap 1u, letter gap 3u,
//   word space 4u of extra silence so that letter gap + word space = 7u).
//
// Parameters
//   UNIT_CYC  clock cycles per Morse time unit (1..65535)
//   CTW       width of the cycle counter, must hold UNIT_CYC-1
//
// Ports
//   clk       in   rising-edge clock
//   nrst      in   asynchronous active-low reset
//   in_valid  in   character offered on in_len/in_code
//   in_ready  out  character can be accepted this cycle
//   in_len    in   element count 1..5, 0 = word space, 6/7 clamp to 5
//   in_code   in   element pattern, bit 0 first, 1 = dash, 0 = dot
//   key       out  Morse key, 1 = mark
//   busy      out  inverse of in_ready
//   done      out  one-cycle pulse when a character and its gap complete
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a character, in_ready high
// S_MARK  | key high for the current element (1u dot / 3u dash)
// S_SPACE | key low for 1u between elements of one character
// S_GAP   | key low for the trailing 3u letter gap (4u for word space)
// ---------------------------------------------------------------------------
module morse_keyer #(
    parameter int UNIT_CYC = 50,
    parameter int CTW      = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_len,
    input  logic [4:0] in_code,
    output logic       key,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MARK  = 2'd1,
        S_SPACE = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [CTW-1:0] r_cyc;
    logic [2:0]     r_units;
    logic [2:0]     r_idx;
    logic [2:0]     r_len;
    logic [4:0]     r_code;

    logic           r_key;
    logic           r_done;
    logic           r_ready;
    logic           r_busy;

    logic           w_accept;
    logic [2:0]     w_len_clamp;
    logic           w_wrap;
    logic           w_unit_end;
    logic [2:0]     w_idx_nxt;
    logic           w_more;
    logic           w_key_nxt;
    logic           w_done_nxt;
    logic           w_ready_nxt;

    assign w_accept    = in_valid && r_ready && (r_state == S_IDLE);
    assign w_len_clamp = (in_len > 3'd5) ? 3'd5 : in_len;
    assign w_wrap      = (r_cyc == CTW'(UNIT_CYC - 1));
    // A state ends on the wrap that consumes its final unit.
    assign w_unit_end  = w_wrap && (r_units == 3'd1);
    assign w_idx_nxt   = r_idx + 3'd1;
    assign w_more      = (w_idx_nxt < r_len);

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_len_clamp == 3'd0) ? S_GAP : S_MARK;
                end
            end
            S_MARK: begin
                if (w_unit_end) begin
                    w_state_nxt = w_more ? S_SPACE : S_GAP;
                end
            end
            S_SPACE: begin
                if (w_unit_end) begin
                    w_state_nxt = S_MARK;
                end
            end
            S_GAP: begin
                if (w_unit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values, registered below so every output is a flop
    always_comb begin
        w_key_nxt   = (w_state_nxt == S_MARK);
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_done_nxt  = (r_state == S_GAP) && (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key   <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_key   <= w_key_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= ~w_ready_nxt;
        end
    end

    // Timing datapath: cycle counter, remaining units, element index
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cyc   <= '0;
            r_units <= 3'd0;
            r_idx   <= 3'd0;
            r_len   <= 3'd0;
            r_code  <= 5'd0;
        end else if (r_state == S_IDLE) begin
            if (w_accept) begin
                r_code <= in_code;
                r_len  <= w_len_clamp;
                r_idx  <= 3'd0;
                r_cyc  <= '0;
                if (w_len_clamp == 3'd0) begin
                    r_units <= 3'd4;
                end else begin
                    r_units <= in_code[0] ? 3'd3 : 3'd1;
                end
            end
        end else begin
            r_cyc <= w_wrap ? '0 : r_cyc + CTW'(1);
            if (w_unit_end) begin
                case (r_state)
                    S_MARK:  r_units <= w_more ? 3'd1 : 3'd3;
                    S_SPACE: begin
                        r_idx   <= w_idx_nxt;
                        r_units <= r_code[w_idx_nxt] ? 3'd3 : 3'd1;
                    end
                    default: r_units <= 3'd0;
                endcase
            end else if (w_wrap) begin
                r_units <= r_units - 3'd1;
            end
        end
    end

    assign key      = r_key;
    assign done     = r_done;
    assign in_ready = r_ready;
    assign busy     = r_busy;

endmodule

// File: tb/tb_morse_keyer.sv
module tb_morse_keyer;

    localparam int U     = 4;
    localparam int BOUND = 400;

    logic       clk      = 1'b0;
    logic       nrst     = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_len   = 3'd0;
    logic [4:0] in_code  = 5'd0;
    logic       in_ready;
    logic       key;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] len;
        logic [4:0] code;
        int         exp_lat;
        int         exp_marks;
    } vec_t;

    vec_t vecs[9];

    morse_keyer #(.UNIT_CYC(U), .CTW(16)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_len   (in_len),
        .in_code  (in_code),
        .key      (key),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model: Morse timing computed directly from element list
    function automatic int clamp_len(input logic [2:0] len);
        return (len > 3'd5) ? 5 : int'(len);
    endfunction

    function automatic int el_units(input logic [4:0] code, input int i);
        return code[i] ? 3 : 1;
    endfunction

    function automatic int exp_len(input logic [2:0] len, input logic [4:0] code);
        int n;
        int t;
        n = clamp_len(len);
        if (n == 0) return 4 * U;
        t = 0;
        for (int i = 0; i < n; i++) t += el_units(code, i) * U;
        t += (n - 1) * U + 3 * U;
        return t;
    endfunction

    function automatic logic exp_key(input logic [2:0] len, input logic [4:0] code, input int c);
        int n;
        int t;
        int d;
        n = clamp_len(len);
        t = 0;
        for (int i = 0; i < n; i++) begin
            d = el_units(code, i) * U;
            if (c >= t && c < t + d) return 1'b1;
            t += d + U;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called just after the accepting edge; returns at the done cycle.
    task automatic run_after_accept(input logic [2:0] len, input logic [4:0] code,
                                    input string nm, output int lat, output int marks);
        int bad;
        int exp_l;
        bad   = 0;
        marks = 0;
        lat   = BOUND;
        exp_l = exp_len(len, code);
        for (int c = 0; c < BOUND; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (key !== exp_key(len, code, c) || busy !== 1'b1 || in_ready !== 1'b0) bad++;
            if (key) marks++;
        end
        chk($sformatf("%s latency", nm), lat, exp_l);
        chk($sformatf("%s trace_mismatches", nm), bad, 0);
        chk($sformatf("%s done_cycle key/busy/ready", nm), int'({key, busy, in_ready}), 1);
    endtask

    task automatic send(input logic [2:0] len, input logic [4:0] code,
                        input string nm, output int lat, output int marks);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("%s ready_before", nm), int'(in_ready), 1);
        in_valid = 1'b1;
        in_len   = len;
        in_code  = code;
        @(posedge clk);
        #1;
        // Scramble the inputs while busy: the latched copy must be used.
        in_valid = 1'b0;
        in_code  = ~code;
        in_len   = 3'($urandom);
        run_after_accept(len, code, nm, lat, marks);
        @(negedge clk);
        chk($sformatf("%s done_fall", nm), int'(done), 0);
    endtask

    initial begin
        int lat;
        int marks;
        int highs;
        logic [2:0] rl;
        logic [4:0] rc;

        // len, code, cycles E0->done, key-high cycles (UNIT = 4)
        vecs[0] = '{3'd1, 5'b00000, 16, 4};   // E
        vecs[1] = '{3'd1, 5'b00001, 24, 12};  // T
        vecs[2] = '{3'd2, 5'b00010, 32, 16};  // A
        vecs[3] = '{3'd0, 5'b10101, 16, 0};   // word space
        vecs[4] = '{3'd7, 5'b11111, 88, 60};  // clamps to five dashes
        vecs[5] = '{3'd6, 5'b00000, 48, 20};  // clamps to five dots
        vecs[6] = '{3'd3, 5'b00000, 32, 12};  // S
        vecs[7] = '{3'd4, 5'b01011, 64, 40};  // dash dash dot dash
        vecs[8] = '{3'd2, 5'b11100, 24, 8};   // upper bits ignored

        // Reset held for 3 cycles with in_valid toggling
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            in_len   = 3'($urandom);
            in_code  = 5'($urandom);
            @(negedge clk);
            chk("reset key/busy/done/ready", int'({key, busy, done, in_ready}), 1);
        end
        in_valid = 1'b0;
        nrst     = 1'b1;

        // Table-driven characters
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].len, vecs[i].code, $sformatf("vec%0d", i), lat, marks);
            chk($sformatf("vec%0d table_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d table_marks", i), marks, vecs[i].exp_marks);
        end

        // Back-to-back: E then T with in_valid held high throughout
        @(negedge clk);
        in_valid = 1'b1;
        in_len   = 3'd1;
        in_code  = 5'd0;
        @(posedge clk);
        #1;
        in_code  = 5'd1;
        run_after_accept(3'd1, 5'd0, "b2b_E", lat, marks);
        chk("b2b_E marks", marks, 4);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_code  = 5'd0;
        run_after_accept(3'd1, 5'd1, "b2b_T", lat, marks);
        chk("b2b_T marks", marks, 12);
        @(negedge clk);
        chk("b2b_T done_fall", int'(done), 0);

        // Reset five cycles into a dash
        @(negedge clk);
        in_valid = 1'b1;
        in_len   = 3'd1;
        in_code  = 5'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        highs = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (key) highs++;
        end
        chk("rst_mid key_high_before", highs, 5);
        #1;
        nrst = 1'b0;
        #1;
        chk("rst_mid async_key", int'(key), 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_mid held key/busy/done/ready", int'({key, busy, done, in_ready}), 1);
        end
        nrst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid after_release key/busy/done/ready", int'({key, busy, done, in_ready}), 1);
        end
        send(3'd1, 5'd0, "rst_mid_E", lat, marks);
        chk("rst_mid_E marks", marks, 4);

        // Randomized characters against the reference model
        for (int i = 0; i < 30; i++) begin
            rl = 3'($urandom_range(0, 7));
            rc = 5'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rl, rc, $sformatf("rand%0d len=%0d code=%b", i, rl, rc), lat, marks);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
